// File: rtl/bit_pop_pkg.sv
// Shared definitions for the bit-population datapath.
//   deser_state_t : deserializer FSM state (IDLE, COLLECT)
//   len_w()       : width needed to hold a count of 0..width, also used to
//                   size the population counter's result.
package bit_pop_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } deser_state_t;

    function automatic int len_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/bit_stream_deserializer_if.sv
// Word-stream interface between a serial bit source, the deserializer and
// its parallel consumer.
//   data_i, data_val_i, last_i        : serial side (source -> deserializer)
//   data_o, data_len_o, data_val_o    : parallel side (deserializer -> consumer)
// modport master : the stimulus/source side
// modport slave  : the deserializer
interface bit_stream_deserializer_if #(
    parameter int WIDTH = 16
);
    import bit_pop_pkg::*;

    localparam int LEN_W = len_w(WIDTH);

    logic             data_i;
    logic             data_val_i;
    logic             last_i;
    logic [WIDTH-1:0] data_o;
    logic [LEN_W-1:0] data_len_o;
    logic             data_val_o;

    modport master (
        output data_i, data_val_i, last_i,
        input  data_o, data_len_o, data_val_o
    );

    modport slave (
        input  data_i, data_val_i, last_i,
        output data_o, data_len_o, data_val_o
    );

endinterface

// File: rtl/bit_stream_deserializer.sv
// Serial-to-parallel deserializer: packs one bit per valid cycle into a
// WIDTH-bit word and presents it with its length and a one-cycle valid pulse.
// A word ends on the WIDTH-th bit or on last_i, whichever comes first;
// partial words are zero-padded.
//
// Ports:
//   clk_i     : clock, rising edge
//   arst_n_i  : asynchronous active-low reset
//   bus       : bit_stream_deserializer_if.slave (serial in, word out)
//
// Build option:
//   DESER_LSB_FIRST_EN defined   -> n-th bit lands in data_o[n-1]
//   DESER_LSB_FIRST_EN undefined -> n-th bit lands in data_o[WIDTH-n]
//
// state   | meaning
// --------+------------------------------------
// IDLE    | no bits held, next bit starts a word
// COLLECT | 1..WIDTH-1 bits held
module bit_stream_deserializer
    import bit_pop_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                       clk_i,
    input  logic                       arst_n_i,
    bit_stream_deserializer_if.slave   bus
);

    localparam int LEN_W = len_w(WIDTH);
    localparam int IDX_W = $clog2(WIDTH);

    deser_state_t     state;
    logic [WIDTH-1:0] asm_q;
    logic [LEN_W-1:0] cnt_q;

    logic [WIDTH-1:0] data_q;
    logic [LEN_W-1:0] len_q;
    logic             data_val_q;

    logic [WIDTH-1:0] asm_cur;
    logic [LEN_W-1:0] cnt_cur;
    logic [IDX_W-1:0] bit_idx;
    logic [WIDTH-1:0] asm_next;
    logic [LEN_W-1:0] cnt_inc;
    logic             word_done;

    // In IDLE nothing is held, so the word starts from a clean slate
    // regardless of what the assembly register contains.
    always_comb begin
        asm_cur = (state == COLLECT) ? asm_q : '0;
        cnt_cur = (state == COLLECT) ? cnt_q : '0;
        cnt_inc = cnt_cur + LEN_W'(1);
`ifdef DESER_LSB_FIRST_EN
        bit_idx = cnt_cur[IDX_W-1:0];
`else
        bit_idx = IDX_W'(WIDTH - 1) - cnt_cur[IDX_W-1:0];
`endif
        asm_next          = asm_cur;
        asm_next[bit_idx] = bus.data_i;
        word_done = bus.last_i || (cnt_inc == LEN_W'(WIDTH));
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state      <= IDLE;
            asm_q      <= '0;
            cnt_q      <= '0;
            data_q     <= '0;
            len_q      <= '0;
            data_val_q <= 1'b0;
        end else begin
            data_val_q <= 1'b0;
            if (bus.data_val_i) begin
                if (word_done) begin
                    // Clear assembly on the completing edge so the very next
                    // bit opens a fresh word without a bubble.
                    data_q     <= asm_next;
                    len_q      <= cnt_inc;
                    data_val_q <= 1'b1;
                    asm_q      <= '0;
                    cnt_q      <= '0;
                    state      <= IDLE;
                end else begin
                    asm_q <= asm_next;
                    cnt_q <= cnt_inc;
                    state <= COLLECT;
                end
            end
        end
    end

    assign bus.data_o     = data_q;
    assign bus.data_len_o = len_q;
    assign bus.data_val_o = data_val_q;

endmodule

// File: tb/tb_bit_stream_deserializer.sv
module tb_bit_stream_deserializer;

    localparam int WIDTH = 8;
    localparam int LEN_W = $clog2(WIDTH + 1);

    typedef struct {
        logic [WIDTH-1:0] word;
        int               len;
        int               cyc;
    } exp_t;

    logic clk;
    logic arst_n;

    bit_stream_deserializer_if #(.WIDTH(WIDTH)) bif();

    bit_stream_deserializer #(.WIDTH(WIDTH)) dut (
        .clk_i    (clk),
        .arst_n_i (arst_n),
        .bus      (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    exp_t exp_q[$];
    bit   model_bits[$];
    logic [WIDTH-1:0] last_word = '0;
    int   last_len = 0;

    // Reference model: a word is the list of accepted bits, turned into a
    // number once it reaches WIDTH bits or is closed by last.
    function automatic logic [WIDTH-1:0] pack_word(input int n);
        int val;
        val = 0;
`ifdef DESER_LSB_FIRST_EN
        for (int i = 0; i < n; i++) val = val + (int'(model_bits[i]) << i);
        return WIDTH'(val);
`else
        for (int i = 0; i < n; i++) val = (val << 1) + int'(model_bits[i]);
        return WIDTH'(val << (WIDTH - n));
`endif
    endfunction

    // Output monitor: compares every cycle against the expected pulse schedule.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            n_checks++;
            if (bif.data_val_o !== 1'b1 || bif.data_o !== exp_q[0].word ||
                bif.data_len_o !== LEN_W'(exp_q[0].len)) begin
                n_fail++;
                $display("FAIL word_out cyc=%0d got val=%b data=%h len=%0d, expected val=1 data=%h len=%0d",
                         cyc, bif.data_val_o, bif.data_o, bif.data_len_o, exp_q[0].word, exp_q[0].len);
            end
            void'(exp_q.pop_front());
        end else begin
            n_checks++;
            if (bif.data_val_o !== 1'b0) begin
                n_fail++;
                $display("FAIL spurious_valid cyc=%0d got val=%b data=%h, expected val=0",
                         cyc, bif.data_val_o, bif.data_o);
            end
        end
    end

    task automatic send_bit(input bit b, input bit last);
        exp_t e;
        @(posedge clk);
        #2;
        bif.data_i     = b;
        bif.data_val_i = 1'b1;
        bif.last_i     = last;
        model_bits.push_back(b);
        if (last || model_bits.size() == WIDTH) begin
            e.len  = model_bits.size();
            e.word = pack_word(e.len);
            e.cyc  = cyc + 1;
            exp_q.push_back(e);
            last_word = e.word;
            last_len  = e.len;
            model_bits.delete();
        end
    endtask

    task automatic idle(input int n, input bit rand_last);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
            bif.data_val_i = 1'b0;
            bif.data_i     = 1'($urandom_range(0, 1));
            bif.last_i     = rand_last ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w);
        logic [WIDTH-1:0] v;
        v = w;
        for (int i = WIDTH - 1; i >= 0; i--) send_bit(v[i], 1'b0);
    endtask

    task automatic test_reset();
        arst_n = 1'b0;
        bif.data_i = 1'b0; bif.data_val_i = 1'b0; bif.last_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bif.data_o !== '0) begin
            n_fail++; $display("FAIL reset_data got %h expected 0", bif.data_o);
        end
        n_checks++;
        if (bif.data_len_o !== '0) begin
            n_fail++; $display("FAIL reset_len got %0d expected 0", bif.data_len_o);
        end
        n_checks++;
        if (bif.data_val_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_val got %b expected 0", bif.data_val_o);
        end
        @(negedge clk);
        arst_n = 1'b1;
        idle(2, 1'b0);
    endtask

    task automatic test_full_word();
        send_word(8'hB2);
        idle(3, 1'b0);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL full_word_pending got %0d expected 0", exp_q.size());
        end
    endtask

    task automatic test_partial();
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b1);
        send_word(8'hFF);
        idle(2, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b1);
        idle(3, 1'b0);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL partial_pending got %0d expected 0", exp_q.size());
        end
    endtask

    task automatic test_gaps_and_hold();
        logic [WIDTH-1:0] w;
        w = 8'hA5;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            send_bit(w[i], 1'b0);
            idle(2, 1'b1);
        end
        idle(4, 1'b1);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL gaps_pending got %0d expected 0", exp_q.size());
        end
        n_checks++;
        if (bif.data_o !== last_word || bif.data_len_o !== LEN_W'(last_len)) begin
            n_fail++;
            $display("FAIL hold_output got data=%h len=%0d expected data=%h len=%0d",
                     bif.data_o, bif.data_len_o, last_word, last_len);
        end
    endtask

    task automatic test_back_to_back();
        send_word(8'h3C);
        send_word(8'hC3);
        send_word(8'h81);
        idle(3, 1'b0);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL b2b_pending got %0d expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid_word();
        send_word(8'h5A);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        @(posedge clk);
        #2;
        bif.data_val_i = 1'b0;
        bif.last_i     = 1'b0;
        #3;
        arst_n = 1'b0;
        model_bits.delete();
        #1;
        n_checks++;
        if (bif.data_o !== '0 || bif.data_len_o !== '0 || bif.data_val_o !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset got data=%h len=%0d val=%b expected all 0",
                     bif.data_o, bif.data_len_o, bif.data_val_o);
        end
        @(posedge clk);
        @(negedge clk);
        arst_n = 1'b1;
        send_word(8'h0F);
        idle(3, 1'b0);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL reset_mid_pending got %0d expected 0", exp_q.size());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0)
                idle(1, 1'b1);
            else
                send_bit(1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
        end
        // flush any partial word with a closing bit
        send_bit(1'($urandom_range(0, 1)), 1'b1);
        idle(3, 1'b0);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL random_pending got %0d expected 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_partial();
        test_gaps_and_hold();
        test_back_to_back();
        test_reset_mid_word();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
